// File: rtl/rvj1_wb_sram_bridge.sv
// Wishbone-classic slave mapping an address window onto NUM_BANKS single-port
// OpenRAM macros, with configurable read latency and error response for holes.
module rvj1_wb_sram_bridge #(
  parameter int          NUM_BANKS    = 2,
  parameter int          BANK_AW      = 9,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o,
  output logic [31:0]               wbs_dat_o,
  output logic [NUM_BANKS-1:0]      sram_csb0,
  output logic [NUM_BANKS-1:0]      sram_web0,
  output logic [4*NUM_BANKS-1:0]    sram_wmask0,
  output logic [BANK_AW*NUM_BANKS-1:0] sram_addr0,
  output logic [32*NUM_BANKS-1:0]   sram_din0,
  input  logic [32*NUM_BANKS-1:0]   sram_dout0
);

  // A single bank still reserves one bank-select bit so the window is never degenerate.
  localparam int BB = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
  localparam int HI = BANK_AW + BB + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_ERR} state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic [BB-1:0]       bank_q;

  logic                hit;
  logic                req;
  logic                populated;
  logic                drive;
  logic [BB-1:0]       bank;
  logic [BANK_AW-1:0]  word;
  logic [31:0]         dout_sel;
  logic                unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit       = (wbs_adr_i[31:HI] == BASE_ADDR[31:HI]);
  assign req       = wbs_cyc_i & wbs_stb_i & hit;
  assign bank      = wbs_adr_i[HI-1:BANK_AW+2];
  assign word      = wbs_adr_i[BANK_AW+1:2];
  assign populated = ({1'b0, bank} < (BB+1)'(NUM_BANKS));

  // A write with no byte lanes is acked but never reaches the macro.
  assign drive = rstn_i && (state == ST_IDLE) && req && populated &&
                 (!wbs_we_i || (wbs_sel_i != 4'b0000));

  always_comb begin
    sram_csb0   = '1;
    sram_web0   = '1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (drive) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank == BB'(b)) begin
          sram_csb0[b]                  = 1'b0;
          sram_web0[b]                  = ~wbs_we_i;
          sram_wmask0[b*4 +: 4]         = wbs_sel_i;
          sram_addr0[b*BANK_AW +: BANK_AW] = word;
          sram_din0[b*32 +: 32]         = wbs_dat_i;
        end
      end
    end
  end

  always_comb begin
    dout_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BB'(b)) dout_sel = sram_dout0[b*32 +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bank_q    <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (!populated) begin
              state     <= ST_ERR;
              wbs_err_o <= 1'b1;
            end else begin
              bank_q <= bank;
              if (wbs_we_i) begin
                state     <= ST_ACK;
                wbs_ack_o <= 1'b1;
              end else begin
                state <= ST_WAIT;
                cnt   <= 2'(READ_LATENCY - 1);
              end
            end
          end
        end
        ST_WAIT: begin
          // Master abandoning the cycle drops the read without touching dat_o.
          if (!wbs_cyc_i) begin
            state <= ST_IDLE;
          end else if (cnt == 2'd0) begin
            wbs_dat_o <= dout_sel;
            wbs_ack_o <= 1'b1;
            state     <= ST_ACK;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvj1_wb_sram_bridge.sv
// Bench for rvj1_wb_sram_bridge: three banks (one hole in the window), latency 3,
// behavioural macros and a flat word-array reference of the window contents.
module tb_rvj1_wb_sram_bridge;

  localparam int          NB   = 3;
  localparam int          AW   = 9;
  localparam int          RL   = 3;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] BANK_BYTES = 32'd2048;
  localparam logic [31:0] WIN  = 32'h0000_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstn;
  logic                cyc, stb, we;
  logic [3:0]          sel;
  logic [31:0]         adr, dat_w;
  logic                ack, err;
  logic [31:0]         dat_r;
  logic [NB-1:0]       csb, web;
  logic [4*NB-1:0]     wmask;
  logic [AW*NB-1:0]    addr;
  logic [32*NB-1:0]    din, dout;

  rvj1_wb_sram_bridge #(
    .NUM_BANKS(NB), .BANK_AW(AW), .BASE_ADDR(BASE), .READ_LATENCY(RL)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(dat_r),
    .sram_csb0(csb), .sram_web0(web), .sram_wmask0(wmask),
    .sram_addr0(addr), .sram_din0(din), .sram_dout0(dout)
  );

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
  endfunction

  // Behavioural macros: sample on the edge, data valid RL cycles later, junk otherwise.
  logic [31:0] smem [NB][512];
  logic [31:0] pipe [NB][RL];
  bit          sinit = 1'b0;

  always @(posedge clk) begin
    if (!sinit) begin
      for (int b = 0; b < NB; b++)
        for (int i = 0; i < 512; i++) smem[b][i] <= init_val(b*512 + i);
      sinit <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (!csb[b] && !web[b])
          for (int l = 0; l < 4; l++)
            if (wmask[b*4+l]) smem[b][addr[b*AW +: AW]][l*8 +: 8] <= din[b*32+l*8 +: 8];
        pipe[b][0] <= (!csb[b] && web[b]) ? smem[b][addr[b*AW +: AW]] : $urandom;
        for (int k = 1; k < RL; k++) pipe[b][k] <= pipe[b][k-1];
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int b = 0; b < NB; b++) dout[b*32 +: 32] = pipe[b][RL-1];
  end

  logic [31:0] rmem [NB*512];
  logic [31:0] last;
  int          tests, fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
  endtask

  // One complete Wishbone transaction, starting on the next cycle.
  task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s);
    logic [31:0]   off;
    int            bank, word, lat, exp_lat;
    logic [NB-1:0] exp_csb;
    bit            busy_idle;
    off = a - BASE;
    @(posedge clk); #1;
    drive_req(a, w, d, s);
    #1;
    chk("prev_resp_cleared", 64'({ack, err}), 64'd0);
    if (off >= WIN) begin
      for (int i = 0; i < 10; i++) begin
        chk("miss_quiet", 64'({ack, err, csb}), 64'({2'b00, {NB{1'b1}}}));
        @(posedge clk); #2;
      end
      release_bus();
      return;
    end
    bank = int'(off / BANK_BYTES);
    word = int'((off >> 2) % 512);
    exp_csb = '1;
    if (bank < NB && (!w || s != 4'h0)) exp_csb[bank] = 1'b0;
    chk("csb_accept", 64'(csb), 64'(exp_csb));
    if (exp_csb != '1) begin
      chk("addr", 64'(addr[bank*AW +: AW]), 64'(word));
      chk("web", 64'(web[bank]), 64'(!w));
      chk("wmask", 64'(wmask[bank*4 +: 4]), 64'(s));
      chk("din", 64'(din[bank*32 +: 32]), 64'(d));
    end
    lat = 0;
    busy_idle = 1'b1;
    while (lat < 12 && !(ack || err)) begin
      @(posedge clk); #2;
      lat++;
      if (csb != '1) busy_idle = 1'b0;
    end
    exp_lat = (bank >= NB || w) ? 1 : RL + 1;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("banks_idle_while_busy", 64'(busy_idle), 64'd1);
    chk("resp", 64'({ack, err}), (bank >= NB) ? 64'd1 : 64'd2);
    if (bank < NB) begin
      if (w) begin
        for (int l = 0; l < 4; l++)
          if (s[l]) rmem[bank*512 + word][l*8 +: 8] = d[l*8 +: 8];
      end else begin
        last = rmem[bank*512 + word];
      end
    end
    chk("dat_o", 64'(dat_r), 64'(last));
    release_bus();
  endtask

  logic [31:0] ra, rd;
  logic [3:0]  rs;
  logic        rw;
  int          rk, rb, rwd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; last = '0;
    for (int i = 0; i < NB*512; i++) rmem[i] = init_val(i);
    rstn = 1'b0;
    release_bus();
    #1;
    drive_req(BASE, 1'b1, 32'h1111_1111, 4'hF);
    #1;
    chk("rst_resp", 64'({ack, err}), 64'd0);
    chk("rst_dat", 64'(dat_r), 64'd0);
    chk("rst_csb_gated", 64'(csb), 64'({NB{1'b1}}));
    release_bus();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // bank 0 write/read
    xact(BASE, 1'b1, 32'hDEAD_BEEF, 4'hF);
    xact(BASE, 1'b0, 32'h0, 4'hF);
    chk("b0_readback", 64'(dat_r), 64'h0000_0000_DEAD_BEEF);

    // bank 1 top word
    xact(BASE + 32'hFFC, 1'b1, 32'h1234_5678, 4'hF);
    xact(BASE + 32'hFFC, 1'b0, 32'h0, 4'hF);
    chk("b1_top_readback", 64'(dat_r), 64'h0000_0000_1234_5678);
    xact(BASE, 1'b0, 32'h0, 4'hF);

    // byte lanes and empty-select write
    xact(BASE + 32'h10, 1'b1, 32'hAABB_CCDD, 4'hF);
    xact(BASE + 32'h10, 1'b1, 32'h1122_3344, 4'b0101);
    xact(BASE + 32'h10, 1'b0, 32'h0, 4'hF);
    chk("byte_lanes", 64'(dat_r), 64'h0000_0000_AA22_CC44);
    xact(BASE + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'h0);
    xact(BASE + 32'h10, 1'b0, 32'h0, 4'hF);
    chk("sel0_no_write", 64'(dat_r), 64'h0000_0000_AA22_CC44);

    // unpopulated bank and misses
    xact(BASE + 32'h1800, 1'b0, 32'h0, 4'hF);
    xact(BASE - 32'd4, 1'b0, 32'h0, 4'hF);
    xact(BASE + WIN, 1'b1, 32'h5555_AAAA, 4'hF);

    // abort in WAIT, then immediate accept
    @(posedge clk); #1;
    drive_req(BASE + 32'h40, 1'b0, 32'h0, 4'hF);
    #1 chk("abort_rd_csb", 64'(csb), 64'({{(NB-1){1'b1}}, 1'b0}));
    @(posedge clk); #2;
    chk("abort_n1", 64'({ack, err}), 64'd0);
    @(posedge clk); #1;
    release_bus();
    #1 chk("abort_n2", 64'({ack, err}), 64'd0);
    @(posedge clk); #1;
    chk("abort_no_ack", 64'({ack, err}), 64'd0);
    chk("abort_dat_hold", 64'(dat_r), 64'(last));
    drive_req(BASE + 32'h44, 1'b1, 32'h0BAD_F00D, 4'hF);
    #1 chk("abort_accept", 64'(csb), 64'({{(NB-1){1'b1}}, 1'b0}));
    @(posedge clk); #2;
    chk("abort_wr_ack", 64'({ack, err}), 64'd2);
    release_bus();
    rmem[17] = 32'h0BAD_F00D;
    xact(BASE + 32'h44, 1'b0, 32'h0, 4'hF);

    // reset in WAIT with the request held
    @(posedge clk); #1;
    drive_req(BASE + 32'hFFC, 1'b0, 32'h0, 4'hF);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("rst_wait_ack", 64'({ack, err}), 64'd0);
    chk("rst_wait_dat", 64'(dat_r), 64'd0);
    chk("rst_wait_csb", 64'(csb), 64'({NB{1'b1}}));
    last = '0;
    repeat (2) @(posedge clk);
    #2 chk("rst_hold_csb", 64'(csb), 64'({NB{1'b1}}));
    release_bus();
    @(posedge clk); #1 rstn = 1'b1;
    xact(BASE + 32'hFFC, 1'b0, 32'h0, 4'hF);

    // randomized traffic over a small working set, including the hole and misses
    for (int t = 0; t < 150; t++) begin
      rk = int'($urandom_range(0, 15));
      if (rk == 0) begin
        ra = BASE - 32'(4 * $urandom_range(1, 64));
      end else if (rk == 1) begin
        ra = BASE + WIN + 32'($urandom_range(0, 4095));
      end else begin
        rb  = int'($urandom_range(0, 3));
        rwd = ($urandom_range(0, 8) == 8) ? 511 : int'($urandom_range(0, 7));
        ra  = BASE + 32'(rb) * BANK_BYTES + 32'(rwd * 4) + 32'($urandom_range(0, 3));
      end
      rs = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      rw = 1'($urandom_range(0, 1));
      rd = $urandom;
      xact(ra, rw, rd, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rvj1_wb_sram_bridge.md
# rvj1_wb_sram_bridge

Parametrised Wishbone-classic slave that maps a contiguous address window onto `NUM_BANKS` sky130 OpenRAM single-port macros (port 0: csb/web/wmask/addr/din/dout). It replaces per-macro hand wiring in `user_project_wrapper`/`rvj1_caravel_soc`: one bridge instance serves IRAM or DRAM banks of any count, with configurable macro read latency, byte-lane writes, and error response for unpopulated banks. The macros are clocked by `clk_i` outside the bridge.

## Interface
- `NUM_BANKS`, 2: number of attached macros (1..8, need not be a power of two).
- `BANK_AW`, 9: word-address width of one macro (512 words for 32x512).
- `BASE_ADDR`, 32'h3000_0000: window base; must be aligned to the window size 4·2^(BANK_AW+BB), where BB = max(1, clog2(NUM_BANKS)).
- `READ_LATENCY`, 1: cycles from the macro sampling edge until `dout0` is valid (1..4).

Ports:
- `clk_i` in 1: clock for the bridge and the macros.
- `rstn_i` in 1: reset, asynchronous assert, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic request.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_err_o` out 1: one-cycle error (unpopulated bank).
- `wbs_dat_o` out 32: read data, valid with ack.
- `sram_csb0` out NUM_BANKS: chip select, active-low, one bit per bank.
- `sram_web0` out NUM_BANKS: write enable, active-low.
- `sram_wmask0` out 4·NUM_BANKS: byte mask per bank.
- `sram_addr0` out BANK_AW·NUM_BANKS: word address per bank.
- `sram_din0` out 32·NUM_BANKS: write data per bank.
- `sram_dout0` in 32·NUM_BANKS: read data per bank.

## Operation
- Hit: `wbs_adr_i[31:BANK_AW+BB+2]` equals the matching bits of `BASE_ADDR`. Misses are ignored completely: no ack, no err, no macro activity.
- Decode: word = `adr[BANK_AW+1:2]`, bank = `adr[BANK_AW+BB+1:BANK_AW+2]`. `adr[1:0]` is ignored.
- FSM states:
  - IDLE: on `cyc&stb&hit`:
    - If bank ≥ NUM_BANKS, go to ERR.
    - Else, during this same cycle, drive the selected bank combinationally: csb=0, web=!we, wmask=sel, addr=word, din=dat_i. Latch the bank index and we.
    - Write: go to ACK. Read: go to WAIT, counter = READ_LATENCY−1.
  - WAIT: decrement the counter. At 0, register the selected bank's `dout0` into `wbs_dat_o` and go to ACK.
  - ACK: `wbs_ack_o`=1 for one cycle, then IDLE.
  - ERR: `wbs_err_o`=1 for one cycle, then IDLE.
- Write with `sel_i`=0: the macro is not selected (csb stays 1), but the write is still acked.
- Non-selected banks, and all banks outside IDLE: csb=1, web=1, wmask=0, addr=0, din=0.
- `wbs_dat_o` changes only on read completion. Writes and errors leave it unchanged.
- Abort: if `cyc_i` deasserts in WAIT, go to IDLE without ack and without updating `dat_o`. ACK and ERR complete regardless of `cyc_i`.
- No new request is accepted in ACK or ERR. The master must drop `stb` after ack/err, per Wishbone classic.
- Reset (asynchronous, any state): FSM goes to IDLE, `ack`=0, `err`=0, `dat_o`=0, counter=0. All SRAM outputs go to their idle values immediately, while `rstn_i` is low.

## Timing
- Request first seen in IDLE in cycle N; the macro samples the command at the end of cycle N.
- Write: ack in cycle N+1.
- Read: data captured at the end of cycle N+READ_LATENCY; ack in cycle N+READ_LATENCY+1. With READ_LATENCY=1, ack is in N+2.
- Error: err in cycle N+1.
- Back-to-back: the earliest next accept is the cycle after ack/err (N+2 for writes).
- `ack_o`, `err_o`, and `dat_o` are registered. SRAM outputs are combinational from the Wishbone inputs, gated by state==IDLE.

## Test plan
- Write/read, bank 0: write 0xDEADBEEF to BASE+0x000 → csb0[0]=0 in cycle N, ack at N+1. Then read BASE+0x000 → ack at N+2, dat_o=0xDEADBEEF. Bank 1 csb stays 1 throughout.
- Bank 1, top word: NUM_BANKS=2, BANK_AW=9. Write 0x12345678 to BASE+0xFFC → bank 1, addr0=0x1FF. Read back returns 0x12345678. Bank 0 is unaffected.
- Byte lanes: word holds 0xAABBCCDD; write 0x11223344 with sel=4'b0101 → read gives 0xAA22CC44. sel=0 write → ack at N+1, csb stays 1, data unchanged.
- Unpopulated bank: NUM_BANKS=3, read bank 3 → err at N+1, no ack, all csb=1, dat_o unchanged. Miss address BASE−4 → no ack/err for 10 cycles.
- Latency/abort: READ_LATENCY=3 read → ack at N+4 with correct data. Repeat with cyc dropped at N+2 → no ack, FSM in IDLE, a new write is accepted at N+3.
- Reset mid-read: assert rstn_i=0 in WAIT → ack=0, dat_o=0, all csb=1 asynchronously. After release, a read completes normally.
